// File: rtl/sync_pkg.sv
// Shared constants for the clk -> clk_2x word synchronizer.
//   DW_DEF / DEPTH_DEF : default payload width and FIFO depth
//   DROP_CNT_W         : width of the dropped-event counter
//   DROP_CNT_MAX       : saturation value of the dropped-event counter
package sync_pkg;

    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned DROP_CNT_W = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/sync_fifo_2x.sv
// DEPTH x DW register FIFO in the clk_2x domain.
//   clk_2x, rst_n : clock, async active-low reset
//   push, wdata   : write request and payload
//   pop           : read request (ignored when empty)
//   rdata_c       : head of FIFO, combinational from the RAM index
//   full_c/empty_c/count_c : occupancy, derived from the pointers
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo_2x #(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic          clk_2x,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata_c,
    output logic          full_c,
    output logic          empty_c,
    output logic [PW-1:0] count_c
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // Occupancy and accept logic; the extra pointer MSB separates full from empty.
    always_comb begin
        empty_c = (wr_ptr == rd_ptr);
        full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count_c = wr_ptr - rd_ptr;
        pop_ok  = pop && !empty_c;
        push_ok = push && (!full_c || pop_ok);
        rdata_c = mem[rd_ptr[AW-1:0]];
    end

    // Pointers wrap naturally at 2*DEPTH.
    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/word_sync_up.sv
// Carries single-cycle events with a DW-bit payload from clk up to clk_2x.
//   clk                 : slow clock, 2:1 with clk_2x, rising edges aligned
//   clk_2x, rst_n       : fast clock, async active-low reset (resets both domains)
//   pulse_in, data_in   : clk-domain event and payload
//   in_full             : clk-domain near-full advisory
//   out_valid/out_data/out_ready : clk_2x-domain FIFO read side
//   ovf_flag, drop_cnt  : sticky overflow flag and saturating drop counter
//   ovf_clr             : clears ovf_flag and drop_cnt
module word_sync_up
    import sync_pkg::*;
#(
    parameter  int unsigned DW    = DW_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_2x,
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pulse_in,
    input  logic [DW-1:0]         data_in,
    output logic                  in_full,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready,
    output logic                  ovf_flag,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    input  logic                  ovf_clr
);

    logic [DW-1:0] cap_data;
    logic          req_tgl;
    logic          tgl_s;
    logic          tgl_d;
    logic          strobe_c;
    logic          pop_c;
    logic          drop_c;
    logic          fifo_full_c;
    logic          fifo_empty_c;
    logic [PW-1:0] fifo_count_c;
    logic [DW-1:0] fifo_rdata_c;

    // Capture stage: payload and request toggle in the slow domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_data <= '0;
            req_tgl  <= 1'b0;
        end else if (pulse_in) begin
            cap_data <= data_in;
            req_tgl  <= ~req_tgl;
        end
    end

    // Near-full advisory, sampled into the slow domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_full <= 1'b0;
        end else begin
            in_full <= (32'(fifo_count_c) >= (DEPTH - 1));
        end
    end

    // Toggle detect; clocks are related so a single sampling flop suffices.
    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            tgl_s <= 1'b0;
            tgl_d <= 1'b0;
        end else begin
            tgl_s <= req_tgl;
            tgl_d <= tgl_s;
        end
    end

    // A push is dropped only when full and no pop frees a slot this cycle.
    always_comb begin
        strobe_c  = tgl_s ^ tgl_d;
        out_valid = !fifo_empty_c;
        out_data  = fifo_rdata_c;
        pop_c     = out_valid && out_ready;
        drop_c    = strobe_c && fifo_full_c && !pop_c;
    end

    sync_fifo_2x #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_2x  (clk_2x),
        .rst_n   (rst_n),
        .push    (strobe_c),
        .wdata   (cap_data),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count_c (fifo_count_c)
    );

    // Overflow bookkeeping; a drop coinciding with a clear counts as the first drop.
    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            ovf_flag <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_CNT_W'(1);
            end else if (drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule
